// File: rtl/control_unit_seq.sv
// Decode-stage control unit: turns an instruction class/opcode into registered
// execute controls and stalls the front end for multi-cycle memory and multiply ops.
module control_unit_seq #(
  parameter int                 CMD_W       = 4,
  parameter int                 MUL_CYCLES  = 4,
  parameter int                 MEM_TIMEOUT = 16,
  parameter logic [CMD_W-1:0]   MUL_CMD     = CMD_W'(4'b1010)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [1:0]       mode,
  input  logic [3:0]       op_code,
  input  logic             s_in,
  input  logic             cond_pass,
  input  logic             hazard,
  input  logic             flush,
  input  logic             mem_ready,
  output logic [CMD_W-1:0] exe_cmd,
  output logic             mem_read,
  output logic             mem_write,
  output logic             wb_enable,
  output logic             s_out,
  output logic             b_out,
  output logic             ctrl_valid,
  output logic             stall_out,
  output logic             mem_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] MUL_BUSY = 2'd2;

  localparam int MUL_W  = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam bit                TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam bit                MUL_MULTI  = (MUL_CYCLES > 1);
  localparam logic [MUL_W-1:0]  MUL_LOAD   = MUL_W'(MUL_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic             rd;
    logic             wr;
    logic             wb;
    logic             s;
    logic             b;
    logic             valid;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  function automatic logic [CMD_W-1:0] cmd4(input logic [3:0] code);
    return CMD_W'(code);
  endfunction

  logic [1:0]        state, state_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [MUL_W-1:0]  mul_cnt, mul_cnt_d;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
  logic              flush_lat, flush_lat_d;

  ctrl_t dec;
  logic  dec_mem;
  logic  dec_mul;
  logic  issue;
  logic  kill;
  logic  timeout_hit;

  // ---------------------------------------------------------------- decode
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    dec     = BUBBLE;
    dec_mem = 1'b0;
    dec_mul = 1'b0;
    unique case (mode)
      2'b00: begin
        dec.valid = 1'b1;
        dec.wb    = 1'b1;
        dec.s     = s_in;
        case (op_code)
          4'b1101: dec.cmd = cmd4(4'b0001);
          4'b1111: dec.cmd = cmd4(4'b1001);
          4'b0100: dec.cmd = cmd4(4'b0010);
          4'b0101: dec.cmd = cmd4(4'b0011);
          4'b0010: dec.cmd = cmd4(4'b0100);
          4'b0110: dec.cmd = cmd4(4'b0101);
          4'b0000: dec.cmd = cmd4(4'b0110);
          4'b1100: dec.cmd = cmd4(4'b0111);
          4'b0001: dec.cmd = cmd4(4'b1000);
          4'b1010: begin
            dec.cmd = cmd4(4'b0100);
            dec.wb  = 1'b0;
            dec.s   = 1'b1;
          end
          4'b1000: begin
            dec.cmd = cmd4(4'b0110);
            dec.wb  = 1'b0;
            dec.s   = 1'b1;
          end
          default: dec = BUBBLE;
        endcase
      end
      2'b01: begin
        // s_in doubles as the L bit: load writes back, store does not
        dec.valid = 1'b1;
        dec.cmd   = cmd4(4'b0010);
        dec.s     = s_in;
        dec.rd    = s_in;
        dec.wr    = ~s_in;
        dec.wb    = s_in;
        dec_mem   = 1'b1;
      end
      2'b10: begin
        dec.valid = 1'b1;
        dec.b     = 1'b1;
        dec.s     = s_in;
      end
      default: begin
        dec.valid = 1'b1;
        dec.cmd   = MUL_CMD;
        dec.s     = s_in;
        dec.wb    = ~MUL_MULTI;
        dec_mul   = MUL_MULTI;
      end
    endcase
  end

  // A latched flush only matters on the cycle that leaves MEM_WAIT.
  assign kill = flush | ((state == MEM_WAIT) & flush_lat) | hazard |
                ~instr_valid | ~cond_pass | ~dec.valid;

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d     = state;
    ctrl_d      = ctrl_q;
    mul_cnt_d   = mul_cnt;
    wait_cnt_d  = wait_cnt;
    flush_lat_d = flush_lat;
    timeout_hit = 1'b0;
    issue       = 1'b0;

    case (state)
      MEM_WAIT: begin
        if (mem_ready) begin
          issue = 1'b1;
        end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
          timeout_hit = 1'b1;
          ctrl_d      = BUBBLE;
          state_d     = IDLE;
          flush_lat_d = 1'b0;
          wait_cnt_d  = '0;
        end else begin
          flush_lat_d = flush_lat | flush;
          if (TIMEOUT_EN) wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      MUL_BUSY: begin
        if (mul_cnt == '0) begin
          issue = 1'b1;
        end else if (flush) begin
          ctrl_d    = BUBBLE;
          mul_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          mul_cnt_d = mul_cnt - 1'b1;
          // writeback is raised for exactly the cycle the counter reads zero
          if (mul_cnt == MUL_W'(1)) ctrl_d.wb = 1'b1;
        end
      end
      default: issue = 1'b1;
    endcase

    if (issue) begin
      flush_lat_d = 1'b0;
      mul_cnt_d   = '0;
      wait_cnt_d  = '0;
      if (kill) begin
        ctrl_d  = BUBBLE;
        state_d = IDLE;
      end else begin
        ctrl_d = dec;
        if (dec_mem) begin
          state_d = MEM_WAIT;
        end else if (dec_mul) begin
          state_d   = MUL_BUSY;
          mul_cnt_d = MUL_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  // ------------------------------------------------------------- registers
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ctrl_q    <= BUBBLE;
      mul_cnt   <= '0;
      wait_cnt  <= '0;
      flush_lat <= 1'b0;
    end else begin
      state     <= state_d;
      ctrl_q    <= ctrl_d;
      mul_cnt   <= mul_cnt_d;
      wait_cnt  <= wait_cnt_d;
      flush_lat <= flush_lat_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign exe_cmd    = ctrl_q.cmd;
  assign mem_read   = ctrl_q.rd;
  assign mem_write  = ctrl_q.wr;
  assign wb_enable  = ctrl_q.wb;
  assign s_out      = ctrl_q.s;
  assign b_out      = ctrl_q.b;
  assign ctrl_valid = ctrl_q.valid;

  // A flush releases the multiply stall in the same cycle it aborts it.
  assign stall_out = rst_n & (((state == MEM_WAIT) & ~mem_ready) |
                              ((state == MUL_BUSY) & (mul_cnt != '0) & ~flush));
  assign mem_err   = rst_n & timeout_hit;

endmodule

// File: tb/tb_control_unit_seq.sv
// Directed bench for control_unit_seq: expected register contents are queued as
// each cycle is driven and compared one edge later.
module tb_control_unit_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [1:0] mode;
  logic [3:0] op_code;
  logic       s_in, cond_pass, hazard, flush, mem_ready;
  logic [3:0] exe_cmd;
  logic       mem_read, mem_write, wb_enable, s_out, b_out, ctrl_valid;
  logic       stall_out, mem_err;

  always #5 clk = ~clk;

  control_unit_seq #(
    .CMD_W      (4),
    .MUL_CYCLES (4),
    .MEM_TIMEOUT(16),
    .MUL_CMD    (4'b1010)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_valid(instr_valid),
    .mode       (mode),
    .op_code    (op_code),
    .s_in       (s_in),
    .cond_pass  (cond_pass),
    .hazard     (hazard),
    .flush      (flush),
    .mem_ready  (mem_ready),
    .exe_cmd    (exe_cmd),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .wb_enable  (wb_enable),
    .s_out      (s_out),
    .b_out      (b_out),
    .ctrl_valid (ctrl_valid),
    .stall_out  (stall_out),
    .mem_err    (mem_err)
  );

  typedef struct packed {
    logic [3:0] cmd;
    logic rd, wr, wb, s, b, v;
  } exp_t;

  localparam exp_t ZERO = '0;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t mk(input logic [3:0] cmd, input logic rd, input logic wr,
                              input logic wb, input logic s, input logic b, input logic v);
    return {cmd, rd, wr, wb, s, b, v};
  endfunction

  // Reference data-processing table
  function automatic exp_t alu_ref(input logic [3:0] op, input logic s);
    case (op)
      4'b1101: return mk(4'b0001, 1'b0, 1'b0, 1'b1, s, 1'b0, 1'b1);
      4'b1111: return mk(4'b1001, 1'b0, 1'b0, 1'b1, s, 1'b0, 1'b1);
      4'b0100: return mk(4'b0010, 1'b0, 1'b0, 1'b1, s, 1'b0, 1'b1);
      4'b0101: return mk(4'b0011, 1'b0, 1'b0, 1'b1, s, 1'b0, 1'b1);
      4'b0010: return mk(4'b0100, 1'b0, 1'b0, 1'b1, s, 1'b0, 1'b1);
      4'b0110: return mk(4'b0101, 1'b0, 1'b0, 1'b1, s, 1'b0, 1'b1);
      4'b0000: return mk(4'b0110, 1'b0, 1'b0, 1'b1, s, 1'b0, 1'b1);
      4'b1100: return mk(4'b0111, 1'b0, 1'b0, 1'b1, s, 1'b0, 1'b1);
      4'b0001: return mk(4'b1000, 1'b0, 1'b0, 1'b1, s, 1'b0, 1'b1);
      4'b1010: return mk(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      4'b1000: return mk(4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      default: return ZERO;
    endcase
  endfunction

  function automatic exp_t mul_exp(input logic wb);
    return mk(4'b1010, 1'b0, 1'b0, wb, 1'b1, 1'b0, 1'b1);
  endfunction

  task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] op,
                       input logic s, input logic cp, input logic hz,
                       input logic fl, input logic mr);
    instr_valid = v;
    mode        = m;
    op_code     = op;
    s_in        = s;
    cond_pass   = cp;
    hazard      = hz;
    flush       = fl;
    mem_ready   = mr;
  endtask

  task automatic drive_ldr();
    drive(1'b1, 2'b01, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive_add(input logic s, input logic mr);
    drive(1'b1, 2'b00, 4'b0100, s, 1'b1, 1'b0, 1'b0, mr);
  endtask

  task automatic drive_idle(input logic fl, input logic mr);
    drive(1'b0, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, fl, mr);
  endtask

  task automatic push(input exp_t e);
    sb.push_back(e);
  endtask

  // Advance one edge and compare the registered outputs with the queue head.
  task automatic tick(input string tag);
    exp_t obs, e;
    @(posedge clk);
    #1;
    obs = {exe_cmd, mem_read, mem_write, wb_enable, s_out, b_out, ctrl_valid};
    e   = (sb.size() > 0) ? sb.pop_front() : 'x;
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  // Combinational outputs for the currently driven inputs.
  task automatic check_comb(input string tag, input logic st, input logic er);
    #1;
    checks++;
    assert ({stall_out, mem_err} === {st, er}) else begin
      failures++;
      $error("FAIL %s observed stall=%b err=%b expected stall=%b err=%b",
             tag, stall_out, mem_err, st, er);
    end
  endtask

  localparam exp_t LDR_E = {4'b0010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam exp_t STR_E = {4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    // Reset with a memory op presented: nothing may stall or err.
    rst_n = 1'b0;
    drive_ldr();
    check_comb("reset_comb", 1'b0, 1'b0);
    push(ZERO); tick("reset_regs");
    check_comb("reset_comb_post", 1'b0, 1'b0);
    rst_n = 1'b1;

    // ADD, CMP, unlisted opcode
    drive_add(1'b1, 1'b0);
    push(mk(4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1)); tick("add");
    drive(1'b1, 2'b00, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(mk(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1)); tick("cmp");
    drive(1'b1, 2'b00, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(ZERO); tick("unlisted_op");

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'b00, 4'(i), i[0], 1'b1, 1'b0, 1'b0, 1'b0);
      push(alu_ref(4'(i), i[0])); tick($sformatf("dp_op%0d", i));
    end

    // Bubble sources
    drive(1'b1, 2'b00, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    push(ZERO); tick("flush_bubble");
    drive(1'b1, 2'b00, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    push(ZERO); tick("hazard_bubble");
    drive(1'b0, 2'b00, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(ZERO); tick("invalid_bubble");
    drive(1'b1, 2'b00, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(ZERO); tick("cond_fail_bubble");

    // mem_ready has no effect in IDLE
    drive_add(1'b0, 1'b1);
    check_comb("idle_mem_ready_comb", 1'b0, 1'b0);
    push(alu_ref(4'b0100, 1'b0)); tick("idle_mem_ready");

    // Branch
    drive(1'b1, 2'b10, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1)); tick("branch");

    // Store with immediate mem_ready
    drive(1'b1, 2'b01, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(STR_E); tick("store");
    drive(1'b1, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_comb("store_exit_comb", 1'b0, 1'b0);
    push(alu_ref(4'b0000, 1'b0)); tick("store_exit");

    // Load: three wait cycles, hazard/valid ignored while stalled
    drive_ldr();
    push(LDR_E); tick("ldr");
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 2'b00, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check_comb($sformatf("ldr_stall%0d", k), 1'b1, 1'b0);
      push(LDR_E); tick($sformatf("ldr_hold%0d", k));
    end
    drive_add(1'b0, 1'b1);
    check_comb("ldr_ready_comb", 1'b0, 1'b0);
    push(alu_ref(4'b0100, 1'b0)); tick("ldr_exit");

    // Flush during MEM_WAIT is remembered and kills the exit instruction
    drive_ldr();
    push(LDR_E); tick("ldr_flush");
    drive(1'b1, 2'b00, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check_comb("flush_in_wait_comb", 1'b1, 1'b0);
    push(LDR_E); tick("flush_in_wait_hold");
    drive_add(1'b1, 1'b1);
    push(ZERO); tick("latched_flush_exit");
    drive_add(1'b1, 1'b0);
    push(alu_ref(4'b0100, 1'b1)); tick("after_latched_flush");

    // Timeout after 16 wait cycles
    drive_ldr();
    push(LDR_E); tick("ldr_timeout");
    for (int k = 1; k <= 16; k++) begin
      drive_idle(1'b0, 1'b0);
      check_comb($sformatf("timeout_comb%0d", k), 1'b1, (k == 16));
      push((k == 16) ? ZERO : LDR_E); tick($sformatf("timeout_regs%0d", k));
    end
    drive_add(1'b1, 1'b0);
    check_comb("post_timeout_comb", 1'b0, 1'b0);
    push(alu_ref(4'b0100, 1'b1)); tick("post_timeout");

    // mem_ready in the timeout cycle wins
    drive_ldr();
    push(LDR_E); tick("ldr_race");
    for (int k = 1; k <= 15; k++) begin
      drive_idle(1'b0, 1'b0);
      push(LDR_E); tick($sformatf("race_hold%0d", k));
    end
    drive_add(1'b1, 1'b1);
    check_comb("ready_at_timeout", 1'b0, 1'b0);
    push(alu_ref(4'b0100, 1'b1)); tick("race_exit");

    // Multiply: 3 stall cycles, writeback in the 4th
    drive(1'b1, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(mul_exp(1'b0)); tick("mul");
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 2'b00, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check_comb($sformatf("mul_stall%0d", k), 1'b1, 1'b0);
      push(mul_exp(k == 3)); tick($sformatf("mul_busy%0d", k));
    end
    drive_idle(1'b0, 1'b0);
    check_comb("mul_last_comb", 1'b0, 1'b0);
    push(ZERO); tick("mul_done");

    // Multiply aborted by flush in its 2nd cycle
    drive(1'b1, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(mul_exp(1'b0)); tick("mul2");
    drive_add(1'b1, 1'b0);
    check_comb("mul2_stall1", 1'b1, 1'b0);
    push(mul_exp(1'b0)); tick("mul2_busy1");
    drive_idle(1'b1, 1'b0);
    check_comb("mul_flush_comb", 1'b0, 1'b0);
    push(ZERO); tick("mul_flush");
    drive_add(1'b1, 1'b0);
    check_comb("after_mul_flush_comb", 1'b0, 1'b0);
    push(alu_ref(4'b0100, 1'b1)); tick("after_mul_flush");

    // Reset in MEM_WAIT
    drive_ldr();
    push(LDR_E); tick("ldr_rst");
    drive_idle(1'b0, 1'b0);
    push(LDR_E); tick("ldr_rst_hold");
    rst_n = 1'b0;
    drive_idle(1'b0, 1'b0);
    check_comb("rst_wait_comb", 1'b0, 1'b0);
    push(ZERO); tick("rst_wait_regs");
    check_comb("rst_wait_post", 1'b0, 1'b0);
    rst_n = 1'b1;
    drive_add(1'b0, 1'b0);
    check_comb("after_rst_comb", 1'b0, 1'b0);
    push(alu_ref(4'b0100, 1'b0)); tick("after_rst");

    // Reset in MUL_BUSY
    drive(1'b1, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    push(mul_exp(1'b0)); tick("mul_rst");
    rst_n = 1'b0;
    drive_idle(1'b0, 1'b0);
    check_comb("rst_mul_comb", 1'b0, 1'b0);
    push(ZERO); tick("rst_mul_regs");
    rst_n = 1'b1;
    drive_add(1'b1, 1'b0);
    check_comb("after_rst_mul_comb", 1'b0, 1'b0);
    push(alu_ref(4'b0100, 1'b1)); tick("after_rst_mul");

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit_seq.md
CONTROL_UNIT_SEQ -- requirements
Module: control_unit_seq

Interface
REQ-001 Parameters, one per line (name, default, meaning), SHALL be:
- CMD_W, 4, exe_cmd width (>=4); 4-bit codes zero-extended.
- MUL_CYCLES, 4, multiply latency in cycles (>=1).
- MEM_TIMEOUT, 16, max MEM_WAIT cycles before abort; 0 disables the timeout.
- MUL_CMD, 4'b1010, exe_cmd code for multiply.
REQ-002 Ports, one per line (name, direction, width, meaning), SHALL be:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, reset, synchronous, active-low.
- instr_valid, in, 1, decode-stage instruction valid.
- mode, in, 2, instruction class.
- op_code, in, 4, data-processing opcode.
- s_in, in, 1, S bit; L bit for memory ops.
- cond_pass, in, 1, condition check passed.
- hazard, in, 1, insert bubble (data hazard).
- flush, in, 1, branch-taken flush.
- mem_ready, in, 1, memory transaction done.
- exe_cmd, out, CMD_W, registered ALU command.
- mem_read, out, 1, registered load.
- mem_write, out, 1, registered store.
- wb_enable, out, 1, registered writeback.
- s_out, out, 1, registered status update.
- b_out, out, 1, registered branch.
- ctrl_valid, out, 1, registered controls are a real instruction.
- stall_out, out, 1, combinational; freeze fetch/decode.
- mem_err, out, 1, one-cycle timeout pulse.

Function
REQ-003 For mode 00, decode SHALL map op_code to exe_cmd, with wb_enable=1 and s_out=s_in: 1101->0001, 1111->1001, 0100->0010, 0101->0011, 0010->0100, 0110->0101, 0000->0110, 1100->0111, 0001->1000.
REQ-004 For mode 00, op 1010 SHALL decode to exe_cmd 0100 and op 1000 to exe_cmd 0110, each with wb_enable=0 and s_out=1.
REQ-005 For mode 01, decode SHALL give exe_cmd 0010 and s_out=s_in, with s_in=1 adding mem_read=1, wb_enable=1 (load) and s_in=0 adding mem_write=1, wb_enable=0 (store).
REQ-006 For mode 10, decode SHALL give b_out=1, exe_cmd=0, s_out=s_in, wb_enable=0.
REQ-007 For mode 11, decode SHALL give exe_cmd=MUL_CMD, s_out=s_in, with wb_enable asserted only in the final multiply cycle.
REQ-008 An unlisted mode 00 opcode SHALL produce a bubble.
REQ-009 A bubble SHALL drive all control outputs and ctrl_valid to 0.
REQ-010 FSM states SHALL be IDLE, MEM_WAIT and MUL_BUSY.
REQ-011 In IDLE with stall_out=0, the output register SHALL load the decoded controls each cycle.
REQ-012 Bubble priority SHALL be: flush, then hazard, then !instr_valid, then !cond_pass; any of these loads a bubble.
REQ-013 An accepted memory op SHALL load its controls and move to MEM_WAIT.
REQ-014 In MEM_WAIT, stall_out SHALL equal !mem_ready and all registered outputs SHALL hold.
REQ-015 MEM_WAIT SHALL return to IDLE on the cycle after mem_ready=1, loading the next decoded instruction.
REQ-016 mem_ready SHALL be ignored outside MEM_WAIT.
REQ-017 Flush SHALL NOT abort MEM_WAIT.
REQ-018 A flush seen during MEM_WAIT SHALL be latched and applied as a bubble on the exit cycle.
REQ-019 If MEM_TIMEOUT>0 and mem_ready stays low for MEM_TIMEOUT cycles in MEM_WAIT, the block SHALL pulse mem_err for one cycle, load a bubble and return to IDLE.
REQ-020 mem_ready=1 on the same cycle as the timeout SHALL take precedence over the timeout, and no mem_err SHALL be raised.
REQ-021 An accepted multiply with MUL_CYCLES>1 SHALL load the down-counter with MUL_CYCLES-1 and enter MUL_BUSY.
REQ-022 In MUL_BUSY, stall_out SHALL be 1 while the counter is non-zero.
REQ-023 In MUL_BUSY, wb_enable SHALL be 1 only while the counter is 0, after which the block returns to IDLE.
REQ-024 With MUL_CYCLES=1, a multiply SHALL behave as a single-cycle op with wb_enable=1 and no MUL_BUSY entry.
REQ-025 A flush in MUL_BUSY SHALL abort the multiply: bubble, counter cleared, next state IDLE, stall_out=0 that cycle.
REQ-026 hazard and instr_valid SHALL be ignored while stall_out=1.

Reset
REQ-027 When rst_n=0 at a rising clk edge, the block SHALL go to IDLE, clear the counters and the latched flush, and drive every registered output to 0.
REQ-028 While rst_n=0, stall_out and mem_err SHALL be 0.
REQ-029 Reset mid-MEM_WAIT or mid-MUL_BUSY SHALL abandon the operation with no mem_err.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- ADD (mode 00, op 0100, s_in=1, valid, cond_pass) -> next cycle exe_cmd=0010, wb_enable=1, s_out=1, ctrl_valid=1.
- CMP (op 1010), then op 0011 -> exe_cmd=0100, wb_enable=0, s_out=1, then a bubble with ctrl_valid=0.
- LDR (mode 01, s_in=1), mem_ready low 3 cycles then high -> stall_out=1 for 3 cycles; mem_read=1 held 4 cycles.
- LDR with mem_ready never high, MEM_TIMEOUT=16 -> mem_err pulse in MEM_WAIT cycle 16, outputs 0 on the next cycle.
- MUL (mode 11), MUL_CYCLES=4 -> stall_out=1 for 3 cycles, wb_enable=1 only in the 4th cycle; with flush in cycle 2 -> bubble, IDLE.
- rst_n=0 during MEM_WAIT -> next edge all outputs 0, mem_err=0, stall_out=0.
